// File: rtl/riscv_pkg.sv
// Shared RISC-V core package.
// Holds the LSU operation/data-type encodings, the rd write-tag width, the
// memory-stage FSM state encoding and the misaligned-access exception causes.
package riscv_pkg;

  localparam int TAG_WIDTH = 4;

  typedef enum logic {
    LSU_LOAD  = 1'b0,
    LSU_STORE = 1'b1
  } lsu_op_e;

  typedef enum logic [2:0] {
    LSU_DTYPE_BYTE   = 3'd0,
    LSU_DTYPE_HALF   = 3'd1,
    LSU_DTYPE_WORD   = 3'd2,
    LSU_DTYPE_U_BYTE = 3'd4,
    LSU_DTYPE_U_HALF = 3'd5
  } lsu_dtype_e;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT_GNT,
    MEM_WAIT_RVALID,
    MEM_DONE
  } mem_state_e;

  localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
  localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;

endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align: combinational byte-lane steering for the memory stage.
//   dtype_i  : access data type
//   offset_i : byte offset within the word (address bits [1:0])
//   wdata_i  : store data from the register file
//   rdata_i  : raw 32-bit word returned by the data bus
//   be_o     : byte enables for the request
//   wdata_o  : store data replicated onto every candidate byte lane
//   rdata_o  : load data shifted down to bit 0 and sign/zero extended
// Halfword and word accesses ignore the offset bits they cannot use, so a
// misaligned access that reaches this block is silently truncated.
module lsu_data_align
  import riscv_pkg::*;
(
  input  lsu_dtype_e  dtype_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [1:0]  lane_off;
  logic [31:0] shifted;

  // NOTE: every output gets a default before the case so that no path
  // through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    lane_off = 2'b00;
    be_o     = 4'b1111;
    wdata_o  = wdata_i;
    unique case (dtype_i)
      LSU_DTYPE_BYTE, LSU_DTYPE_U_BYTE: begin
        lane_off = offset_i;
        be_o     = 4'b0001 << offset_i;
        wdata_o  = {4{wdata_i[7:0]}};
      end
      LSU_DTYPE_HALF, LSU_DTYPE_U_HALF: begin
        lane_off = {offset_i[1], 1'b0};
        be_o     = 4'b0011 << {offset_i[1], 1'b0};
        wdata_o  = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase

    shifted = rdata_i >> {lane_off, 3'b000};
    rdata_o = shifted;
    unique case (dtype_i)
      LSU_DTYPE_BYTE:   rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      LSU_DTYPE_U_BYTE: rdata_o = {24'h0, shifted[7:0]};
      LSU_DTYPE_HALF:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      LSU_DTYPE_U_HALF: rdata_o = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage between execute and writeback.
//   clk, reset_n       : clock, asynchronous active-low reset
//   stall_M, ready_mem : hold from the pipeline controller / stage accepts EX->MEM
//   lsu_*_mem          : load/store access from EX
//   rd_wr_*_mem        : destination register from EX
//   exc_*_mem          : exception carried from earlier stages
//   data_*             : data-memory request/grant/rvalid bus
//   rd_wr_*_wb, wb_valid, exc_*_wb : registered writeback outputs
//   forward_mem_*      : same-cycle ALU result forwarding
// Build option: define MEM_MISALIGN_EXC_EN to turn misaligned half/word
// accesses into load/store misaligned exceptions instead of masking the
// low address bits.
module mem_stage
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall_M,
  output logic                 ready_mem,
  input  logic                 lsu_en_mem,
  input  lsu_op_e              lsu_op_mem,
  input  lsu_dtype_e           lsu_dtype_mem,
  input  logic [31:0]          lsu_addr_mem,
  input  logic [31:0]          lsu_wdata_mem,
  input  logic                 rd_wr_en_mem,
  input  logic [TAG_WIDTH-1:0] rd_wr_tag_mem,
  input  logic [4:0]           rd_wr_addr_mem,
  input  logic [31:0]          rd_wr_data_mem,
  input  logic                 exc_taken_mem,
  input  logic [5:0]           exc_cause_mem,
  input  logic [31:0]          exc_tval_mem,
  output logic                 data_req,
  input  logic                 data_gnt,
  output logic [31:0]          data_addr,
  output logic                 data_we,
  output logic [3:0]           data_be,
  output logic [31:0]          data_wdata,
  input  logic                 data_rvalid,
  input  logic [31:0]          data_rdata,
  output logic                 wb_valid,
  output logic                 rd_wr_en_wb,
  output logic [TAG_WIDTH-1:0] rd_wr_tag_wb,
  output logic [4:0]           rd_wr_addr_wb,
  output logic [31:0]          rd_wr_data_wb,
  output logic                 exc_taken_wb,
  output logic [5:0]           exc_cause_wb,
  output logic [31:0]          exc_tval_wb,
  output logic                 forward_mem_en,
  output logic [TAG_WIDTH-1:0] forward_mem_tag,
  output logic [4:0]           forward_mem_addr,
  output logic [31:0]          forward_mem_wdata
);

  mem_state_e           state_q;
  logic [31:0]          rdata_buf_q;
  logic                 wb_valid_q, rd_wr_en_wb_q, exc_taken_wb_q;
  logic [TAG_WIDTH-1:0] rd_wr_tag_wb_q;
  logic [4:0]           rd_wr_addr_wb_q;
  logic [31:0]          rd_wr_data_wb_q, exc_tval_wb_q;
  logic [5:0]           exc_cause_wb_q;

  logic        is_load, is_store, misalign, exc_any, access_pend;
  logic        gnt_hit, rvalid_hit, complete;
  logic [31:0] load_data, rdata_src;

  assign is_load  = (lsu_op_mem == LSU_LOAD);
  assign is_store = lsu_en_mem & (lsu_op_mem == LSU_STORE);

`ifdef MEM_MISALIGN_EXC_EN
  assign misalign = lsu_en_mem & ~exc_taken_mem &
                    ((((lsu_dtype_mem == LSU_DTYPE_HALF) | (lsu_dtype_mem == LSU_DTYPE_U_HALF))
                      & lsu_addr_mem[0]) |
                     ((lsu_dtype_mem == LSU_DTYPE_WORD) & (lsu_addr_mem[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign exc_any     = exc_taken_mem | misalign;
  assign access_pend = lsu_en_mem & ~exc_any;

  // Gated with reset_n so an in-flight request drops the moment reset asserts.
  assign data_req  = reset_n & (((state_q == MEM_IDLE) & access_pend) | (state_q == MEM_WAIT_GNT));
  assign data_addr = {lsu_addr_mem[31:2], 2'b00};
  assign data_we   = (lsu_op_mem == LSU_STORE);

  assign gnt_hit    = data_req & data_gnt;
  assign rvalid_hit = (state_q == MEM_WAIT_RVALID) & data_rvalid;
  // A store granted under stall parks in DONE so it is not re-issued.
  assign complete   = (gnt_hit & ~is_load) | rvalid_hit | (state_q == MEM_DONE);
  assign ready_mem  = ~stall_M & (~lsu_en_mem | exc_any | complete);

  assign rdata_src = (state_q == MEM_DONE) ? rdata_buf_q : data_rdata;

  lsu_data_align u_align (
    .dtype_i  (lsu_dtype_mem),
    .offset_i (lsu_addr_mem[1:0]),
    .wdata_i  (lsu_wdata_mem),
    .rdata_i  (rdata_src),
    .be_o     (data_be),
    .wdata_o  (data_wdata),
    .rdata_o  (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= MEM_IDLE;
      rdata_buf_q <= '0;
    end else begin
      unique case (state_q)
        MEM_IDLE, MEM_WAIT_GNT: begin
          if (gnt_hit) begin
            if (is_load)      state_q <= MEM_WAIT_RVALID;
            else if (stall_M) state_q <= MEM_DONE;
            else              state_q <= MEM_IDLE;
          end else if (data_req) begin
            state_q <= MEM_WAIT_GNT;
          end
        end
        MEM_WAIT_RVALID: begin
          if (data_rvalid) begin
            if (stall_M) begin
              state_q     <= MEM_DONE;
              rdata_buf_q <= data_rdata;
            end else begin
              state_q <= MEM_IDLE;
            end
          end
        end
        MEM_DONE: if (!stall_M) state_q <= MEM_IDLE;
        default:  state_q <= MEM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q      <= 1'b0;
      rd_wr_en_wb_q   <= 1'b0;
      rd_wr_tag_wb_q  <= '0;
      rd_wr_addr_wb_q <= '0;
      rd_wr_data_wb_q <= '0;
      exc_taken_wb_q  <= 1'b0;
      exc_cause_wb_q  <= '0;
      exc_tval_wb_q   <= '0;
    end else if (ready_mem) begin
      wb_valid_q      <= 1'b1;
      rd_wr_en_wb_q   <= rd_wr_en_mem & ~exc_any & ~is_store;
      rd_wr_tag_wb_q  <= rd_wr_tag_mem;
      rd_wr_addr_wb_q <= rd_wr_addr_mem;
      rd_wr_data_wb_q <= (lsu_en_mem & is_load & ~exc_any) ? load_data : rd_wr_data_mem;
      exc_taken_wb_q  <= exc_any;
      exc_cause_wb_q  <= exc_taken_mem ? exc_cause_mem :
                         misalign      ? (is_load ? EXC_LD_MISALIGN : EXC_ST_MISALIGN) : 6'd0;
      exc_tval_wb_q   <= exc_taken_mem ? exc_tval_mem :
                         misalign      ? lsu_addr_mem : 32'h0;
    end else if (!stall_M) begin
      // Bubble: the access is still in flight, nothing retires this edge.
      wb_valid_q     <= 1'b0;
      rd_wr_en_wb_q  <= 1'b0;
      exc_taken_wb_q <= 1'b0;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign rd_wr_en_wb   = rd_wr_en_wb_q;
  assign rd_wr_tag_wb  = rd_wr_tag_wb_q;
  assign rd_wr_addr_wb = rd_wr_addr_wb_q;
  assign rd_wr_data_wb = rd_wr_data_wb_q;
  assign exc_taken_wb  = exc_taken_wb_q;
  assign exc_cause_wb  = exc_cause_wb_q;
  assign exc_tval_wb   = exc_tval_wb_q;

  assign forward_mem_en    = rd_wr_en_mem & ~lsu_en_mem & ~exc_taken_mem;
  assign forward_mem_tag   = rd_wr_tag_mem;
  assign forward_mem_addr  = rd_wr_addr_mem;
  assign forward_mem_wdata = rd_wr_data_mem;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory pipeline stage. It sits directly downstream of the execute stage and consumes its registered `*_mem` outputs. It runs loads and stores on the data-memory request/grant/rvalid bus and sign- or zero-extends load data. It registers results and exceptions into the writeback-stage registers, and provides a same-cycle forwarding path for ALU results.

## Interface
- `TAG_WIDTH`, from riscv_pkg: width of the rd write tag.
- `clk` in 1: clock; all registers are rising-edge.
- `reset_n` in 1: asynchronous active-low reset.
- `stall_M` in 1: the pipeline controller holds this stage.
- `ready_mem` out 1: this stage accepts the current EX→MEM contents at the next edge.
- `lsu_en_mem`, `lsu_op_mem` (lsu_op_e), `lsu_dtype_mem` (lsu_dtype_e), `lsu_addr_mem`[31:0], `lsu_wdata_mem`[31:0] in: the access from EX.
- `rd_wr_en_mem`, `rd_wr_tag_mem`[TAG_WIDTH], `rd_wr_addr_mem`[4:0], `rd_wr_data_mem`[31:0] in: the destination from EX.
- `exc_taken_mem`, `exc_cause_mem`[5:0], `exc_tval_mem`[31:0] in: an exception carried from earlier stages.
- `data_req` out 1, `data_gnt` in 1, `data_addr` out 32, `data_we` out 1, `data_be` out 4, `data_wdata` out 32: data bus request channel.
- `data_rvalid` in 1, `data_rdata` in 32: data bus response channel.
- `wb_valid`, `rd_wr_en_wb`, `rd_wr_tag_wb`, `rd_wr_addr_wb`[4:0], `rd_wr_data_wb`[31:0] out: registered writeback.
- `exc_taken_wb`, `exc_cause_wb`[5:0], `exc_tval_wb`[31:0] out: registered exception.
- `forward_mem_en`, `forward_mem_tag`, `forward_mem_addr`[4:0], `forward_mem_wdata`[31:0] out: combinational forwarding.

## Operation
- FSM states:
  - IDLE → WAIT_GNT: `lsu_en_mem & ~exc_taken_mem` and the access is legal. In IDLE, `data_req` is driven combinationally.
  - WAIT_GNT → WAIT_RVALID on `data_gnt` for a load; WAIT_GNT → IDLE on `data_gnt` for a store.
  - A grant in the IDLE cycle itself skips WAIT_GNT.
  - WAIT_RVALID → IDLE on `data_rvalid` when `~stall_M`. If `stall_M` is high, it goes to DONE instead, and `data_rdata` is captured in `rdata_buf`.
  - DONE → IDLE when `~stall_M`.
- `data_req` is high in IDLE (with a legal access pending) and in WAIT_GNT.
- `data_addr`, `data_we`, `data_be` and `data_wdata` are stable from request to grant.
- `data_addr` is `{lsu_addr_mem[31:2],2'b00}`.
- Byte enables: byte = `4'b0001<<addr[1:0]`; half = `4'b0011<<{addr[1],1'b0}`; word = `4'b1111`.
- Store data is replicated to the byte lanes: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`.
- Load data is shifted right by the byte offset, then extended. LSU_DTYPE_BYTE and HALF sign-extend; U_BYTE and U_HALF zero-extend; WORD passes unchanged.
- `ready_mem = ~stall_M & (non-LSU | exception | completing this cycle)`. Completing means a store granted, or a load rvalid (or DONE) with `~stall_M`.
- On the edge where `ready_mem` is high, the writeback registers load:
  - `wb_valid = 1`.
  - The rd fields come from the inputs.
  - Data is the extended load value for loads, otherwise `rd_wr_data_mem`.
  - Stores write `rd_wr_en_wb = 0`.
- When `ready_mem` is low and `~stall_M`, a bubble is inserted: `wb_valid = 0` and `rd_wr_en_wb = 0`.
- When `stall_M` is high, all writeback registers hold.
- An incoming `exc_taken_mem` suppresses the bus access and passes through in one cycle.
- `forward_mem_en = rd_wr_en_mem & ~lsu_en_mem & ~exc_taken_mem`. `forward_mem_wdata = rd_wr_data_mem`.
- Simultaneous events:
  - `data_gnt` and `data_rvalid` in the same cycle apply to different transactions. `data_rvalid` is ignored outside WAIT_RVALID.
  - A new access is never issued while the FSM is not IDLE.

## Timing
- Non-LSU instruction: latency 1 cycle (inputs → `*_wb`).
- Store with immediate grant: 1 cycle.
- Load with immediate grant and next-cycle rvalid: 2 cycles; `ready_mem` is low in the first cycle.
- Each extra cycle without `data_gnt` or `data_rvalid` adds 1 cycle.
- Reset: FSM to IDLE; `data_req` 0; all `*_wb`, `exc_*_wb` and `rdata_buf` are 0.
- Reset mid-transaction aborts immediately: `data_req` drops asynchronously and the outstanding response is discarded.

## Configuration
- With `MEM_MISALIGN_EXC_EN` defined:
  - A misaligned half (`addr[0]`) or word (`addr[1:0]!=0`) issues no request.
  - It completes in 1 cycle with `exc_taken_wb = 1`.
  - `exc_cause_wb` is 4 for a load and 6 for a store; `exc_tval_wb` is the address.
  - `rd_wr_en_wb = 0`.
- Without the macro: no check. The low bits are masked: half uses `addr[1]` only, word uses `be = 4'b1111`.

## Structure
- riscv_pkg (shared package):
  - Existing: `lsu_op_e`, `lsu_dtype_e`, `TAG_WIDTH`.
  - New: `mem_state_e` {MEM_IDLE, MEM_WAIT_GNT, MEM_WAIT_RVALID, MEM_DONE}, and the exception cause constants `EXC_LD_MISALIGN = 4` and `EXC_ST_MISALIGN = 6`.
- One sub-module, `lsu_data_align` (combinational): byte-enable and store-lane generation, plus load shift/extend.

## Test plan
- ALU op: `rd_wr_data_mem = 32'h1234`, `rd x5` → next edge `rd_wr_data_wb = 32'h1234`, `wb_valid = 1`; `forward_mem_en = 1` in the same cycle.
- LB at address `0x103`, `rdata = 32'h80FF_00AA`, grant immediate, rvalid +1 cycle → `data_be = 4'b1000`, `rd_wr_data_wb = 32'hFFFF_FF80`, latency 2.
- SH at address `0x102`, `wdata = 32'h0000_BEEF`, grant delayed 3 cycles → `data_be = 4'b1100`, `data_wdata = 32'hBEEF_BEEF`; `ready_mem` low for 3 cycles; `rd_wr_en_wb = 0`.
- LW with `stall_M` high when rvalid arrives (`rdata = 32'hCAFE_F00D`) → DONE; `rd_wr_data_wb = 32'hCAFE_F00D` on the first edge after stall release.
- With `MEM_MISALIGN_EXC_EN`, LW at `0x101` → `data_req` never asserted; `exc_taken_wb = 1`, cause 4, tval `0x101`.
- `reset_n` low during WAIT_RVALID → `data_req = 0` and all outputs 0 immediately; the late rvalid after reset is ignored.
